i2c_codec_responder: RTL and testbench

Synthesizable I2C target (responder) that models the write-only control port of the WM8731 audio codec, the device our I2C initializer talks to. It watches SCLK/SDAT, recognises START/STOP, checks the device address, ACKs valid bytes by pulling SDAT low, and presents each completed 24-bit write as a 7-bit register address plus 9-bit register data with a one-cycle valid strobe. It lets board-level simulation, and an optional FPGA loopback self-test, check the initializer's sequence without a real codec.

---
 rtl/i2c_codec_responder.sv | 168 ++++++++++++++++
 tb/tb_i2c_codec_responder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_codec_responder.sv
// I2C write-only target modelling the WM8731 control port: ACKs {DEV_ADDR,W} frames
// of two data bytes and presents each committed write as 7-bit address plus 9-bit data.
module i2c_codec_responder #(
  parameter logic [6:0] DEV_ADDR   = 7'h1A,
  parameter int         MAX_WRITES = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_I2C_SCLK,
  inout  wire        io_I2C_SDAT,
  output logic [6:0] o_reg_addr,
  output logic [8:0] o_reg_data,
  output logic       o_valid,
  output logic       o_err,
  output logic [4:0] o_count,
  output logic       o_busy
);

  localparam logic [4:0] CNT_MAX = 5'(MAX_WRITES);

  typedef enum logic [3:0] {
    IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, WAIT_STOP, IGNORE
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] sclk_sync, sdat_sync;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [1:0] byte_cnt, byte_cnt_nxt;
  logic       byte_done, byte_done_nxt;
  logic       seen_rise, seen_rise_nxt;
  logic       err_nxt, commit_nxt, commit_q;
  logic       sda_low_q;
  logic [7:0] shift_q, byte1_q, byte2_q;
  logic       scl_rise, scl_fall, scl_hi, start_det, stop_det;

  // Stage 0: two-flop synchronizers plus one history flop for edge detection
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sclk_sync <= '1;
      sdat_sync <= '1;
    end else begin
      sclk_sync <= {sclk_sync[1:0], i_I2C_SCLK};
      sdat_sync <= {sdat_sync[1:0], io_I2C_SDAT};
    end
  end

  // START/STOP only count when SCLK was stable high, so a same-cycle SCLK edge wins
  assign scl_rise  =  sclk_sync[1] & ~sclk_sync[2];
  assign scl_fall  = ~sclk_sync[1] &  sclk_sync[2];
  assign scl_hi    =  sclk_sync[1] &  sclk_sync[2];
  assign start_det = scl_hi & ~sdat_sync[1] &  sdat_sync[2];
  assign stop_det  = scl_hi &  sdat_sync[1] & ~sdat_sync[2];

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    byte_cnt_nxt  = byte_cnt;
    byte_done_nxt = byte_done;
    seen_rise_nxt = seen_rise;
    err_nxt       = o_err;
    commit_nxt    = 1'b0;
    if (scl_rise || scl_fall) begin
      unique case (state)
        ADDR, BYTE1, BYTE2: begin
          if (scl_rise) begin
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) byte_done_nxt = 1'b1;
          end else if (byte_done) begin
            byte_done_nxt = 1'b0;
            if (state == ADDR)       state_nxt = (shift_q == {DEV_ADDR, 1'b0}) ? ACK_A : IGNORE;
            else if (state == BYTE1) state_nxt = ACK_1;
            else                     state_nxt = ACK_2;
          end
        end
        ACK_A: if (scl_fall) state_nxt = BYTE1;
        ACK_1: if (scl_fall) begin
          state_nxt    = BYTE2;
          byte_cnt_nxt = 2'd1;
        end
        ACK_2: if (scl_fall) begin
          state_nxt     = WAIT_STOP;
          byte_cnt_nxt  = 2'd2;
          seen_rise_nxt = 1'b0;
        end
        // A rise alone may be the lead-in to STOP; a following fall means a third data byte
        WAIT_STOP: begin
          if (scl_rise) seen_rise_nxt = 1'b1;
          else if (seen_rise) begin
            err_nxt   = 1'b1;
            state_nxt = IGNORE;
          end
        end
        default: ;
      endcase
    end else if (start_det) begin
      if (byte_cnt != 2'd0) err_nxt = 1'b1;
      state_nxt     = ADDR;
      bit_cnt_nxt   = 3'd0;
      byte_cnt_nxt  = 2'd0;
      byte_done_nxt = 1'b0;
    end else if (stop_det) begin
      byte_cnt_nxt = 2'd0;
      unique case (state)
        IDLE, IGNORE: state_nxt = IDLE;
        WAIT_STOP: begin
          commit_nxt = 1'b1;
          state_nxt  = IDLE;
        end
        default: begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Stage 1: frame state, three cycles after a pin edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      byte_cnt  <= 2'd0;
      byte_done <= 1'b0;
      seen_rise <= 1'b0;
      o_err     <= 1'b0;
      commit_q  <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      byte_cnt  <= byte_cnt_nxt;
      byte_done <= byte_done_nxt;
      seen_rise <= seen_rise_nxt;
      o_err     <= err_nxt;
      commit_q  <= commit_nxt;
      o_busy    <= (state_nxt != IDLE);
    end
  end

  always_ff @(posedge i_clk) begin
    if (scl_rise && (state == ADDR || state == BYTE1 || state == BYTE2))
      shift_q <= {shift_q[6:0], sdat_sync[1]};
    if (scl_fall && byte_done && state == BYTE1) byte1_q <= shift_q;
    if (scl_fall && byte_done && state == BYTE2) byte2_q <= shift_q;
  end

  // Stage 2: registered SDAT pull-down and commit outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sda_low_q  <= 1'b0;
      o_valid    <= 1'b0;
      o_reg_addr <= 7'd0;
      o_reg_data <= 9'd0;
      o_count    <= 5'd0;
    end else begin
      sda_low_q <= (state == ACK_A) || (state == ACK_1) || (state == ACK_2);
      o_valid   <= commit_q;
      if (commit_q) begin
        o_reg_addr <= byte1_q[7:1];
        o_reg_data <= {byte1_q[0], byte2_q};
        if (o_count < CNT_MAX) o_count <= o_count + 5'd1;
      end
    end
  end

  assign io_I2C_SDAT = sda_low_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Bench for i2c_codec_responder: bit-banged I2C initiator with a scoreboard of expected commits.
`timescale 1ns/1ps
module tb_i2c_codec_responder;

  localparam int Q    = 5;
  localparam int MAXW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic scl   = 1'b1;
  logic m_low = 1'b0;
  wire  sdat;

  pullup (sdat);
  assign sdat = m_low ? 1'b0 : 1'bz;

  logic [6:0] reg_addr;
  logic [8:0] reg_data;
  logic       valid, err, busy;
  logic [4:0] count;

  always #5 clk = ~clk;

  i2c_codec_responder #(.DEV_ADDR(7'h1A), .MAX_WRITES(MAXW)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_I2C_SCLK (scl),
    .io_I2C_SDAT(sdat),
    .o_reg_addr (reg_addr),
    .o_reg_data (reg_data),
    .o_valid    (valid),
    .o_err      (err),
    .o_count    (count),
    .o_busy     (busy)
  );

  typedef struct packed {
    logic [6:0] a;
    logic [8:0] d;
    logic [4:0] c;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_mis = 0, exp_cnt = 0, dut_low_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (sdat === 1'b0 && !m_low) dut_low_cnt++;
    if (valid === 1'b1) begin
      if (sb.size() == 0) check_eq("unexpected_valid", valid, 0);
      else begin
        e = sb.pop_front();
        check_eq("commit_addr", reg_addr, e.a);
        check_eq("commit_data", reg_data, e.d);
        check_eq("commit_count", count, e.c);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_low = 1'b0; tick(Q);
    scl   = 1'b1; tick(Q);
    m_low = 1'b1; tick(Q);
    scl   = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; tick(Q);
    scl   = 1'b1; tick(Q);
    m_low = 1'b0; tick(Q);
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      m_low = ~b[i]; tick(Q);
      scl   = 1'b1;  tick(2*Q);
      scl   = 1'b0;  tick(Q);
    end
  endtask

  task automatic recv_ack(output logic ack);
    m_low = 1'b0; tick(Q);
    scl   = 1'b1; tick(Q);
    ack   = (sdat === 1'b0);
    tick(Q);
    scl   = 1'b0; tick(Q);
  endtask

  task automatic send_frame(input logic [31:0] f, input int n, input bit do_stop,
                            output logic [3:0] acks);
    logic a;
    acks = '0;
    i2c_start();
    for (int i = 0; i < n; i++) begin
      send_bits(f[31-8*i -: 8]);
      recv_ack(a);
      acks[i] = a;
    end
    if (do_stop) i2c_stop();
  endtask

  task automatic expect_commit(input logic [7:0] b1, input logic [7:0] b2);
    exp_t e;
    if (exp_cnt < MAXW) exp_cnt++;
    e.a = b1[7:1];
    e.d = {b1[0], b2};
    e.c = 5'(exp_cnt);
    sb.push_back(e);
  endtask

  task automatic settle(input string tag);
    tick(10);
    check_eq(tag, sb.size(), 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  acks;
    logic        a;
    int          low0;
    logic [15:0] tbl [3];
    tbl = '{16'h0815, 16'h0C00, 16'h1201};

    tick(3);
    check_eq("rst_addr", reg_addr, 0);
    check_eq("rst_data", reg_data, 0);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_sdat", sdat, 1);
    rst_n = 1'b1;
    tick(Q);

    // single write 34_1E_00
    expect_commit(8'h1E, 8'h00);
    send_frame(32'h341E0000, 3, 1'b1, acks);
    check_eq("t1_acks", acks, 4'b0111);
    settle("t1_drained");
    check_eq("t1_count", count, 1);
    check_eq("t1_err", err, 0);
    check_eq("t1_busy", busy, 0);

    // back-to-back init sequence
    for (int k = 0; k < 3; k++) begin
      expect_commit(tbl[k][15:8], tbl[k][7:0]);
      send_frame({8'h34, tbl[k], 8'h00}, 3, 1'b1, acks);
      check_eq("t2_acks", acks, 4'b0111);
    end
    settle("t2_drained");
    check_eq("t2_addr", reg_addr, 7'h09);
    check_eq("t2_data", reg_data, 9'h001);
    check_eq("t2_count", count, exp_cnt);
    check_eq("t2_err", err, 0);

    // transfer to another device
    low0 = dut_low_cnt;
    send_frame(32'h36AA5500, 3, 1'b1, acks);
    check_eq("t3_acks", acks, 4'b0000);
    settle("t3_drained");
    check_eq("t3_no_drive", dut_low_cnt - low0, 0);
    check_eq("t3_count", count, exp_cnt);
    check_eq("t3_err", err, 0);

    // STOP after only one data byte
    i2c_start();
    check_eq("t4_busy", busy, 1);
    send_bits(8'h34); recv_ack(a); check_eq("t4_ack_a", a, 1);
    send_bits(8'h08); recv_ack(a); check_eq("t4_ack_1", a, 1);
    i2c_stop();
    settle("t4_drained");
    check_eq("t4_err", err, 1);
    check_eq("t4_busy", busy, 0);
    check_eq("t4_count", count, exp_cnt);

    // extra fourth byte, then a clean write
    send_frame(32'h340815AA, 4, 1'b1, acks);
    check_eq("t5_acks", acks, 4'b0111);
    settle("t5_drained");
    check_eq("t5_err", err, 1);
    check_eq("t5_count", count, exp_cnt);
    expect_commit(8'h0E, 8'h42);
    send_frame(32'h340E4200, 3, 1'b1, acks);
    check_eq("t5b_acks", acks, 4'b0111);
    settle("t5b_drained");
    check_eq("t5b_addr", reg_addr, 7'h07);
    check_eq("t5b_data", reg_data, 9'h042);

    // reset while the address ACK is being driven
    i2c_start();
    send_bits(8'h34);
    m_low = 1'b0;
    tick(3);
    check_eq("t6_ack_driven", sdat, 0);
    rst_n = 1'b0;
    #1;
    check_eq("t6_sdat_released", sdat, 1);
    check_eq("t6_addr", reg_addr, 0);
    check_eq("t6_data", reg_data, 0);
    check_eq("t6_valid", valid, 0);
    check_eq("t6_err", err, 0);
    check_eq("t6_count", count, 0);
    check_eq("t6_busy", busy, 0);
    exp_cnt = 0;
    tick(2);
    rst_n = 1'b1;
    tick(Q);
    expect_commit(8'h1E, 8'h00);
    send_frame(32'h341E0000, 3, 1'b1, acks);
    check_eq("t6b_acks", acks, 4'b0111);
    settle("t6b_drained");
    check_eq("t6b_count", count, 1);
    check_eq("t6b_err", err, 0);

    // repeated START: harmless before data, an error after a data byte
    i2c_start();
    send_bits(8'h34); recv_ack(a); check_eq("t7_ack_a", a, 1);
    i2c_start();
    check_eq("t7_err_nodata", err, 0);
    check_eq("t7_busy", busy, 1);
    send_bits(8'h34); recv_ack(a);
    send_bits(8'h08); recv_ack(a); check_eq("t7_ack_1", a, 1);
    i2c_start();
    check_eq("t7_err_data", err, 1);
    expect_commit(8'h10, 8'h20);
    send_bits(8'h34); recv_ack(a);
    send_bits(8'h10); recv_ack(a);
    send_bits(8'h20); recv_ack(a); check_eq("t7_ack_2", a, 1);
    i2c_stop();
    settle("t7_drained");
    check_eq("t7_addr", reg_addr, 7'h08);
    check_eq("t7_data", reg_data, 9'h020);

    // counter saturation
    for (int k = 0; k < MAXW; k++) begin
      expect_commit(8'h0B, 8'(k * 7));
      send_frame({16'h340B, 8'(k * 7), 8'h00}, 3, 1'b1, acks);
    end
    settle("t8_drained");
    check_eq("t8_count_sat", count, MAXW);
    check_eq("t8_data", reg_data, {1'b1, 8'(15 * 7)});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
